// File: rtl/reg_file_sb.sv
// Register file with combinational read ports, WB write-through bypass and a
// per-register pending-write counter used by ID to detect RAW hazards.

module reg_file_sb_rd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PEND_W = 2,
  parameter int NREG   = 32
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic [NREG-1:0][DATA_W-1:0]  regs,
  input  logic [NREG-1:0][PEND_W-1:0]  cnt,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         retire,
  output logic [DATA_W-1:0]            data,
  output logic                         busy
);
  logic              addr_nz;
  logic              wr_hit;
  logic [PEND_W-1:0] cnt_nxt;

  assign addr_nz = (addr != '0);
  assign wr_hit  = wr_en & (wr_addr == addr) & addr_nz;
  assign data    = !addr_nz ? '0 : (wr_hit ? wr_data : regs[addr]);

  // Busy looks at the count after this cycle's retire; a same-cycle claim
  // belongs to the instruction leaving ID, not to the one reading here.
  assign cnt_nxt = cnt[addr] - PEND_W'(retire & (wr_addr == addr));
  assign busy    = addr_nz & (cnt_nxt != '0);
endmodule

module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int PEND_W = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
  input  logic [NUM_RD-1:0]          rd_use_i,
  output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]          rd_busy_o,
  output logic                       stall_o,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       claim_en_i,
  input  logic [ADDR_W-1:0]          claim_addr_i,
  output logic                       claim_ready_o
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0][PEND_W-1:0] cnt;
  logic wr_nz, claim_nz, retire, claim_hit, claim_acc;

  assign wr_nz     = (wr_addr_i != '0);
  assign claim_nz  = (claim_addr_i != '0);
  assign retire    = wr_en_i & wr_nz & (cnt[wr_addr_i] != '0);
  assign claim_hit = retire & (wr_addr_i == claim_addr_i);
  // cnt[0] is tied to zero, so address 0 always reports ready.
  assign claim_ready_o = (cnt[claim_addr_i] != CNT_MAX) | claim_hit;
  assign claim_acc     = claim_en_i & claim_ready_o & claim_nz;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                regs <= '0;
    else if (wr_en_i && wr_nz) regs[wr_addr_i] <= wr_data_i;
  end

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic              inc, dec;
    logic [PEND_W-1:0] c;

    assign inc = claim_acc & (claim_addr_i == ADDR_W'(r));
    assign dec = retire & (wr_addr_i == ADDR_W'(r));

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)          c <= '0;
      else if (inc && !dec) c <= c + 1'b1;
      else if (dec && !inc) c <= c - 1'b1;
    end

    assign cnt[r] = c;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_sb_rd #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .PEND_W (PEND_W),
      .NREG   (NREG)
    ) u_rd (
      .addr    (rd_addr_i[k*ADDR_W +: ADDR_W]),
      .regs    (regs),
      .cnt     (cnt),
      .wr_en   (wr_en_i),
      .wr_addr (wr_addr_i),
      .wr_data (wr_data_i),
      .retire  (retire),
      .data    (rd_data_o[k*DATA_W +: DATA_W]),
      .busy    (rd_busy_o[k])
    );
  end

  assign stall_o = |(rd_busy_o & rd_use_i);
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios then random traffic, all checked
// against an array/counter model of the register file and scoreboard.

module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int PMAX = 3;

  logic            clk_i, rst_i;
  logic [NR*AW-1:0] rd_addr_i;
  logic [NR-1:0]   rd_use_i;
  logic [NR*DW-1:0] rd_data_o;
  logic [NR-1:0]   rd_busy_o;
  logic            stall_o;
  logic            wr_en_i;
  logic [AW-1:0]   wr_addr_i;
  logic [DW-1:0]   wr_data_i;
  logic            claim_en_i;
  logic [AW-1:0]   claim_addr_i;
  logic            claim_ready_o;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PEND_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_addr_i(rd_addr_i), .rd_use_i(rd_use_i), .rd_data_o(rd_data_o),
    .rd_busy_o(rd_busy_o), .stall_o(stall_o),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .claim_en_i(claim_en_i), .claim_addr_i(claim_addr_i),
    .claim_ready_o(claim_ready_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [DW-1:0] mem [32];
  int            pend [32];
  int            vectors = 0;
  int            miscompares = 0;

  function automatic logic m_ready(input int ca);
    return (ca == 0) || (pend[ca] < PMAX) ||
           (wr_en_i && int'(wr_addr_i) == ca && pend[ca] > 0);
  endfunction

  task automatic check(input string tag);
    logic [NR-1:0] exp_busy;
    logic          exp_stall;
    exp_busy = '0;
    for (int k = 0; k < NR; k++) begin
      int a;
      int after;
      logic [DW-1:0] ed;
      a = int'(rd_addr_i[k*AW +: AW]);
      if (a == 0) ed = '0;
      else if (wr_en_i && int'(wr_addr_i) == a) ed = wr_data_i;
      else ed = mem[a];
      after = pend[a];
      if (wr_en_i && int'(wr_addr_i) == a && after > 0) after--;
      exp_busy[k] = (a != 0) && (after != 0);
      vectors++;
      assert (rd_data_o[k*DW +: DW] === ed) else begin
        miscompares++;
        $error("FAIL %s data[%0d] got %h exp %h", tag, k, rd_data_o[k*DW +: DW], ed);
      end
    end
    exp_stall = |(exp_busy & rd_use_i);
    vectors++;
    assert (rd_busy_o === exp_busy) else begin
      miscompares++;
      $error("FAIL %s busy got %b exp %b", tag, rd_busy_o, exp_busy);
    end
    vectors++;
    assert (stall_o === exp_stall) else begin
      miscompares++;
      $error("FAIL %s stall got %b exp %b", tag, stall_o, exp_stall);
    end
    vectors++;
    assert (claim_ready_o === m_ready(int'(claim_addr_i))) else begin
      miscompares++;
      $error("FAIL %s claim_ready got %b exp %b", tag, claim_ready_o, m_ready(int'(claim_addr_i)));
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      mem[r]  = '0;
      pend[r] = 0;
    end
  endtask

  task automatic step(input logic [NR*AW-1:0] ra, input logic [NR-1:0] use_v,
                      input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic ce, input logic [AW-1:0] ca, input string tag);
    logic acc, ret;
    @(negedge clk_i);
    rd_addr_i = ra; rd_use_i = use_v;
    wr_en_i = we; wr_addr_i = wa; wr_data_i = wd;
    claim_en_i = ce; claim_addr_i = ca;
    #1 check(tag);
    acc = ce && (ca != 0) && m_ready(int'(ca));
    ret = we && (wa != 0) && (pend[wa] > 0);
    @(posedge clk_i);
    if (acc) pend[ca]++;
    if (ret) pend[wa]--;
    if (we && wa != 0) mem[wa] = wd;
  endtask

  function automatic logic [NR*AW-1:0] ra3(input int a2, input int a1, input int a0);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  initial begin
    model_clear();
    rst_i = 1'b0;
    rd_addr_i = '0; rd_use_i = '0;
    wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    claim_en_i = 1'b0; claim_addr_i = '0;
    #2 check("por");
    @(negedge clk_i) rst_i = 1'b1;

    // write/read, r0 protection
    step(ra3(0,0,5), 3'b000, 1, 5, 32'hDEADBEEF, 0, 0, "wr5");
    step(ra3(0,0,5), 3'b001, 0, 0, 0, 0, 0, "rd5");
    step(ra3(0,0,0), 3'b000, 1, 0, 32'h1234, 1, 0, "wr0");
    step(ra3(0,5,0), 3'b011, 0, 0, 0, 0, 0, "rd0");
    // bypass
    step(ra3(0,7,0), 3'b010, 1, 7, 32'h55AA55AA, 0, 0, "byp");
    // RAW
    step(ra3(0,0,0), 3'b000, 0, 0, 0, 1, 3, "claim3");
    step(ra3(0,0,3), 3'b001, 0, 0, 0, 0, 0, "raw_stall");
    step(ra3(0,0,3), 3'b001, 1, 3, 32'd9, 0, 0, "raw_wr");
    step(ra3(0,0,3), 3'b001, 0, 0, 0, 0, 0, "raw_after");
    // saturation
    for (int i = 0; i < 3; i++) step(ra3(0,0,4), 3'b001, 0, 0, 0, 1, 4, "sat_claim");
    step(ra3(0,0,4), 3'b001, 0, 0, 0, 1, 4, "sat_full");
    step(ra3(0,0,4), 3'b001, 1, 4, 32'hA, 1, 4, "sat_cw");
    for (int i = 0; i < 3; i++) step(ra3(0,0,4), 3'b001, 1, 4, 32'(i + 16), 0, 4, "sat_drain");
    step(ra3(0,0,4), 3'b001, 1, 4, 32'h77, 0, 4, "sat_under");
    // multi-port
    step(ra3(0,0,0), 3'b000, 0, 0, 0, 1, 2, "claim2");
    step(ra3(0,2,2), 3'b100, 0, 0, 0, 0, 0, "mp_nostall");
    step(ra3(0,2,2), 3'b001, 0, 0, 0, 0, 0, "mp_stall");
    // asynchronous reset with state pending
    step(ra3(0,0,0), 3'b000, 0, 0, 0, 1, 6, "claim6");
    @(negedge clk_i);
    rd_addr_i = ra3(2,5,7); rd_use_i = 3'b111;
    wr_en_i = 1'b0; claim_en_i = 1'b0; claim_addr_i = AW'(2);
    #2 rst_i = 1'b0;
    model_clear();
    #1 check("reset");
    @(negedge clk_i) rst_i = 1'b1;
    step(ra3(6,2,5), 3'b111, 0, 0, 0, 0, 6, "post_rst");

    // random traffic on a small address window to force collisions
    for (int n = 0; n < 400; n++) begin
      step(ra3($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,7)),
           NR'($urandom), 1'($urandom), AW'($urandom_range(0,7)), $urandom,
           1'($urandom), AW'($urandom_range(0,7)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
